// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (count, big-endian words, XOR checksum),
// writes the words into imem and holds the cpu in reset until the image verifies.
module imem_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                r_state, w_state;
  logic [15:0]           r_cnt, w_cnt;
  logic [7:0]            r_hi, w_hi;
  logic [7:0]            r_xor, w_xor;
  logic                  r_in_ready, w_in_ready;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [15:0]           r_wdata, w_wdata;
  logic                  r_cpu_rst, w_cpu_rst;
  logic                  r_done, w_done;
  logic                  r_error, w_error;
  logic [ADDR_WIDTH:0]   r_words, w_words;

  logic                  w_accept;
  logic [15:0]           w_cnt_full;
  logic [ADDR_WIDTH:0]   w_words_inc;

  assign w_accept    = in_valid && r_in_ready;
  assign w_cnt_full  = {r_cnt[15:8], in_data};
  assign w_words_inc = r_words + 1'b1;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_hi      = r_hi;
    w_xor     = r_xor;
    w_we      = 1'b0;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_cpu_rst = r_cpu_rst;
    w_done    = r_done;
    w_error   = r_error;
    w_words   = r_words;

    if (reload) begin
      // Restart framing; a byte offered in the same cycle is dropped.
      w_state   = S_HDR_HI;
      w_cpu_rst = 1'b1;
      w_done    = 1'b0;
      w_error   = 1'b0;
      w_xor     = 8'h00;
      w_words   = '0;
    end else if (w_accept) begin
      if (r_state != S_CSUM) w_xor = r_xor ^ in_data;
      case (r_state)
        S_HDR_HI: begin
          w_cnt   = {in_data, 8'h00};
          w_state = S_HDR_LO;
        end
        S_HDR_LO: begin
          w_cnt = w_cnt_full;
          if ({1'b0, w_cnt_full} > 17'(DEPTH)) begin
            w_state = S_ERR;
            w_error = 1'b1;
          end else if (w_cnt_full == 16'h0000) begin
            w_state = S_CSUM;
          end else begin
            w_state = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          w_hi    = in_data;
          w_state = S_DATA_LO;
        end
        S_DATA_LO: begin
          // words_loaded doubles as the write index of the current word.
          w_we    = 1'b1;
          w_addr  = r_words[ADDR_WIDTH-1:0];
          w_wdata = {r_hi, in_data};
          w_words = w_words_inc;
          w_state = (16'(w_words_inc) == r_cnt) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: begin
          if (in_data == r_xor) begin
            w_state   = S_DONE;
            w_done    = 1'b1;
            w_cpu_rst = 1'b0;
          end else begin
            w_state = S_ERR;
            w_error = 1'b1;
          end
        end
        default: ;
      endcase
    end

    w_in_ready = (w_state != S_DONE) && (w_state != S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HDR_HI;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_xor      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_hi       <= w_hi;
      r_xor      <= w_xor;
      r_in_ready <= w_in_ready;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_cpu_rst  <= w_cpu_rst;
      r_done     <= w_done;
      r_error    <= w_error;
      r_words    <= w_words;
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors, oversize, reload and async reset.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, cpu_rst, done, error;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wq_addr[$];
  logic [15:0]   wq_data[$];
  logic          prev_we = 1'b0;
  int            we_double = 0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: one entry per strobe, and flag any strobe lasting two cycles.
  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
      $display("write addr=%0d data=%04h", imem_addr, imem_wdata);
    end
    if (imem_we && prev_we) we_double++;
    prev_we = imem_we;
  end

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    we_double = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("byte %02h sent (gap %0d)", b, gap);
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_main_writes(input string tag);
    logic [AW-1:0] ea[3] = '{8'd0, 8'd1, 8'd2};
    logic [15:0]   ed[3] = '{16'h0123, 16'h1456, 16'h7000};
    n_checks++;
    if (wq_addr.size() != 3) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d required 3", tag, wq_addr.size());
    end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_checks++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: got (%0d,%04h) required (%0d,%04h)",
                 tag, i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      end
    end
    n_checks++;
    if (we_double != 0) begin
      n_fail++;
      $display("FAIL %s_we_width: %0d multi-cycle strobes, required 0", tag, we_double);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_rst, done, error, in_ready, imem_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: cpu_rst,done,error,in_ready,we=%05b required 10000",
               {cpu_rst, done, error, in_ready, imem_we});
    end
    n_checks++;
    if (imem_addr !== '0 || imem_wdata !== 16'h0 || words_loaded !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d wdata=%04h words=%0d required 0,0000,0",
               imem_addr, imem_wdata, words_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[$] = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h14, 8'h56, 8'h70, 8'h00, 8'h13};
    clear_writes();
    send_frame(f, 0);
    n_checks++;
    if ({done, cpu_rst, error, in_ready} !== 4'b1000 || words_loaded !== 9'd3) begin
      n_fail++;
      $display("FAIL b2b_final: done,cpu_rst,error,in_ready=%04b words=%0d required 1000 words=3",
               {done, cpu_rst, error, in_ready}, words_loaded);
    end
    check_main_writes("b2b");
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: in_ready=%0b done=%0b required 0,1", in_ready, done);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[$] = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h14, 8'h56, 8'h70, 8'h00, 8'h12};
    do_reload();
    n_checks++;
    if ({cpu_rst, done, error, in_ready} !== 4'b1001 || words_loaded !== 9'd0) begin
      n_fail++;
      $display("FAIL reload_state: cpu_rst,done,error,in_ready=%04b words=%0d required 1001 words=0",
               {cpu_rst, done, error, in_ready}, words_loaded);
    end
    clear_writes();
    send_frame(f, 0);
    n_checks++;
    if ({error, done, cpu_rst, in_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL badcsum_final: error,done,cpu_rst,in_ready=%04b required 1010",
               {error, done, cpu_rst, in_ready});
    end
    check_main_writes("badcsum");
    $display("test_bad_csum done");
  endtask

  task automatic test_oversize();
    logic [7:0] f[$] = '{8'h01, 8'h01};
    do_reload();
    clear_writes();
    send_frame(f, 0);
    n_checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_error: error=%0b in_ready=%0b done=%0b required 1,0,0",
               error, in_ready, done);
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (wq_addr.size() != 0 || in_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_nowrite: writes=%0d in_ready=%0b cpu_rst=%0b required 0,0,1",
               wq_addr.size(), in_ready, cpu_rst);
    end
    $display("test_oversize done");
  endtask

  task automatic test_zero_len();
    logic [7:0] fg[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] fb[$] = '{8'h00, 8'h00, 8'h05};
    do_reload();
    clear_writes();
    send_frame(fg, 0);
    n_checks++;
    if ({done, cpu_rst, error} !== 3'b100 || wq_addr.size() != 0 || words_loaded !== 9'd0) begin
      n_fail++;
      $display("FAIL zero_good: done,cpu_rst,error=%03b writes=%0d words=%0d required 100,0,0",
               {done, cpu_rst, error}, wq_addr.size(), words_loaded);
    end
    do_reload();
    send_frame(fb, 0);
    n_checks++;
    if ({error, done, cpu_rst} !== 3'b101) begin
      n_fail++;
      $display("FAIL zero_bad: error,done,cpu_rst=%03b required 101", {error, done, cpu_rst});
    end
    $display("test_zero_len done");
  endtask

  task automatic test_gaps();
    logic [7:0] f[$] = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h14, 8'h56, 8'h70, 8'h00, 8'h13};
    do_reload();
    clear_writes();
    send_frame(f, 5);
    n_checks++;
    if ({done, cpu_rst, error, in_ready} !== 4'b1000 || words_loaded !== 9'd3) begin
      n_fail++;
      $display("FAIL gaps_final: done,cpu_rst,error,in_ready=%04b words=%0d required 1000 words=3",
               {done, cpu_rst, error, in_ready}, words_loaded);
    end
    check_main_writes("gaps");
    $display("test_gaps done");
  endtask

  task automatic test_reload();
    logic [7:0] f[$] = '{8'h00, 8'h01, 8'h60, 8'h05, 8'h64};
    do_reload();
    // Reload while in_ready=1 with a byte offered: 0x55 would make the header oversize if consumed.
    @(negedge clk);
    reload = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    reload = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({cpu_rst, done, error, in_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reload_flags: cpu_rst,done,error,in_ready=%04b required 1001",
               {cpu_rst, done, error, in_ready});
    end
    clear_writes();
    send_frame(f, 0);
    n_checks++;
    if ({done, cpu_rst, error} !== 3'b100 || words_loaded !== 9'd1) begin
      n_fail++;
      $display("FAIL reload_final: done,cpu_rst,error=%03b words=%0d required 100 words=1",
               {done, cpu_rst, error}, words_loaded);
    end
    n_checks++;
    if (wq_addr.size() != 1 || (wq_addr.size() == 1 && (wq_addr[0] !== 8'd0 || wq_data[0] !== 16'h6005))) begin
      n_fail++;
      $display("FAIL reload_write: count=%0d first=(%0d,%04h) required 1,(0,6005)",
               wq_addr.size(), (wq_addr.size() > 0) ? wq_addr[0] : 8'd0,
               (wq_data.size() > 0) ? wq_data[0] : 16'h0);
    end
    $display("test_reload done");
  endtask

  task automatic test_async_rst();
    logic [7:0] f[$]  = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    logic [7:0] f2[$] = '{8'h00, 8'h01, 8'h60, 8'h05, 8'h64};
    do_reload();
    clear_writes();
    send_frame(f, 0);
    in_valid = 1'b1;
    in_data  = 8'h44;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cpu_rst, done, error, in_ready, imem_we} !== 5'b10000 ||
        imem_addr !== '0 || imem_wdata !== 16'h0 || words_loaded !== '0) begin
      n_fail++;
      $display("FAIL async_rst: flags=%05b addr=%0d wdata=%04h words=%0d required 10000,0,0000,0",
               {cpu_rst, done, error, in_ready, imem_we}, imem_addr, imem_wdata, words_loaded);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || wq_addr.size() != 1) begin
      n_fail++;
      $display("FAIL async_release: in_ready=%0b writes=%0d required 1,1", in_ready, wq_addr.size());
    end
    @(negedge clk);
    send_frame(f2, 0);
    n_checks++;
    if ({done, cpu_rst, error} !== 3'b100 || words_loaded !== 9'd1) begin
      n_fail++;
      $display("FAIL async_fresh: done,cpu_rst,error=%03b words=%0d required 100 words=1",
               {done, cpu_rst, error}, words_loaded);
    end
    $display("test_async_rst done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bad_csum();
    test_oversize();
    test_zero_len();
    test_gaps();
    test_reload();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader sitting directly upstream of the cpu's instruction memory. It receives a framed byte stream, assembles big-endian 16-bit instruction words and writes them sequentially into imem through a single write port. It holds the cpu in reset until a complete, checksum-valid image has been written, then releases it. It replaces hand-initialised IMEM contents in simulation and on hardware.

Parameters:
DEPTH, 256, number of 16-bit words in imem; the maximum accepted image size.
ADDR_WIDTH, 8, imem word-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high.
reload  input  1  synchronous pulse; abort or finish the current state and restart framing.
in_valid  input  1  in_data holds a byte.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
imem_we  output  1  imem write strobe, one cycle per word.
imem_addr  output  ADDR_WIDTH  imem word address.
imem_wdata  output  16  instruction word.
cpu_rst  output  1  drives cpu rst; high except in DONE.
done  output  1  image loaded and verified.
error  output  1  frame rejected (oversize or bad checksum).
words_loaded  output  ADDR_WIDTH+1  count of words written in the current frame.

Behaviour:
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N words sent high byte first, then a 1-byte checksum equal to the XOR of every preceding frame byte.
- FSM states: HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR. All outputs are registered.
- Reset (asynchronous): state=HDR_HI, cpu_rst=1, done=0, error=0, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, running XOR=0, in_ready=0. in_ready rises on the first edge after rst deasserts.
- in_ready is 1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO and CSUM. It is 0 in DONE and ERR. in_valid with in_ready=0 is ignored; no byte is consumed.
- Every accepted byte updates xor_acc ^= in_data, except the checksum byte itself.
- HDR_HI to HDR_LO on accept, latching the count high byte.
- HDR_LO on accept:
  - N > DEPTH: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA_HI with word index=0.
- DATA_HI to DATA_LO on accept, latching the high byte.
- DATA_LO on accept at edge E:
  - At edge E: imem_we=1, imem_addr=index, imem_wdata={hi,in_data}, words_loaded=index+1.
  - imem_we returns to 0 at edge E+1. Throughput is at most one write per two cycles; no stall is ever needed.
  - Next state is CSUM if index+1 == N, else DATA_HI.
- CSUM on accept at edge E:
  - in_data == xor_acc: state=DONE, done=1 and cpu_rst=0 at edge E.
  - Mismatch: state=ERR, error=1 at edge E, cpu_rst stays 1.
- ERR from oversize: error=1 at the HDR_LO accept edge. No imem writes are issued.
- DONE and ERR hold indefinitely until reload or rst.
- reload=1 in any state at edge E:
  - At edge E: state=HDR_HI, cpu_rst=1, done=0, error=0, xor_acc=0, words_loaded=0, imem_we=0.
  - Any byte presented in that same cycle is not consumed.
  - imem contents are not cleared.
- Gaps in in_valid, of any length and in any state, do not affect the result.
- Asynchronous rst mid-frame discards the partial frame. Words already written remain in imem, but cpu_rst=1, so the partial image is never executed.

Test Plan:
- Stream 00 03 01 23 14 56 70 00 13 back-to-back -> writes (0,0x0123), (1,0x1456), (2,0x7000), each a single-cycle imem_we; then done=1, cpu_rst=0, words_loaded=3 on the checksum edge, and in_ready=0 thereafter.
- Same frame with checksum 0x12 -> the three writes occur, then error=1, done=0, cpu_rst stays 1, in_ready=0.
- Header 01 01 (N=257 > DEPTH=256) -> error=1 on the second byte's edge, zero imem_we pulses, following bytes not accepted.
- Stream 00 00 00 -> no writes, done=1, cpu_rst=0. Stream 00 00 05 -> error=1.
- First frame sent with random 0-5 cycle in_valid gaps -> identical write sequence and final state to the back-to-back case.
- After DONE, pulse reload and send 00 01 60 05 64 -> cpu_rst=1 the cycle after reload, write (0,0x6005), then done=1. Assert rst mid-DATA_LO -> all outputs at reset values immediately (asynchronous), and after release the loader accepts a fresh header.
